// File: rtl/bit_alloc_pkg.sv
// bit_alloc_pkg: shared state encoding, default width and index-width derivation
package bit_alloc_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/bit_alloc_if.sv
// bit_alloc_if: allocation/free handshake and occupancy view of the slot allocator
interface bit_alloc_if
    import bit_alloc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    localparam int IDX_W = idx_w(WIDTH);
    logic             alloc_req;
    logic             alloc_ready;
    logic             alloc_valid;
    logic [IDX_W-1:0] alloc_index;
    logic             alloc_fail;
    logic             free_req;
    logic [IDX_W-1:0] free_index;
    logic             free_err;
    logic [WIDTH-1:0] occ;
    logic             busy;
    modport master (
        output alloc_req, free_req, free_index,
        input  alloc_ready, alloc_valid, alloc_index, alloc_fail, free_err, occ, busy
    );
    modport slave (
        input  alloc_req, free_req, free_index,
        output alloc_ready, alloc_valid, alloc_index, alloc_fail, free_err, occ, busy
    );
endinterface

// File: rtl/bit_alloc_bit_write.sv
// bit_write: returns word with the bit at index replaced by value
module bit_write
    import bit_alloc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]        word,
    input  logic [idx_w(WIDTH)-1:0] index,
    input  logic                    value,
    output logic [WIDTH-1:0]        result
);
    always_comb begin
        result = word;
        result[index] = value;
    end
endmodule

// File: rtl/bit_alloc.sv
// bit_alloc: sequential lowest-free-slot allocator over a registered occupancy word
module bit_alloc
    import bit_alloc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    bit_alloc_if.slave bus
);
    localparam int IDX_W = idx_w(WIDTH);
    localparam logic [IDX_W-1:0] last_idx = IDX_W'(WIDTH - 1);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d;
    logic [WIDTH-1:0] occ_q, occ_d, occ_clr, occ_fr, occ_set;
    logic             valid_q, valid_d, fail_q, fail_d, err_q, err_d, hit;

    // The free is applied before the grant so a same-edge free of the scanned bit is re-granted.
    bit_write #(.WIDTH(WIDTH)) u_free (
        .word(occ_q), .index(bus.free_index), .value(1'b0), .result(occ_clr)
    );
    bit_write #(.WIDTH(WIDTH)) u_grant (
        .word(occ_fr), .index(ptr_q), .value(1'b1), .result(occ_set)
    );

    assign occ_fr = bus.free_req ? occ_clr : occ_q;
    assign hit    = (state_q == SCAN) && !occ_fr[ptr_q];
    assign err_d  = bus.free_req && !occ_q[bus.free_index];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        occ_d   = occ_fr;
        valid_d = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = bus.alloc_req ? SCAN : IDLE;
                ptr_d   = '0;
            end
            SCAN: begin
                state_d = (hit || ptr_q == last_idx) ? DONE : SCAN;
                ptr_d   = (hit || ptr_q == last_idx) ? ptr_q : ptr_q + 1'b1;
                occ_d   = hit ? occ_set : occ_fr;
                idx_d   = hit ? ptr_q : idx_q;
                valid_d = hit;
                fail_d  = !hit && ptr_q == last_idx;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
        end
    end

    assign bus.alloc_ready = state_q == IDLE;
    assign bus.busy        = state_q != IDLE;
    assign bus.alloc_valid = valid_q;
    assign bus.alloc_fail  = fail_q;
    assign bus.alloc_index = idx_q;
    assign bus.free_err    = err_q;
    assign bus.occ         = occ_q;
endmodule

// File: tb/tb_bit_alloc.sv
// tb_bit_alloc: randomized scoreboard bench for bit_alloc against a timeline model of the slot rules
module tb_bit_alloc;
    localparam int W = 4;
    typedef struct { bit fail; int idx; int occ; int cyc; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    bit   free_prev = 1'b0;
    logic [W-1:0] m = '0;
    exp_t exp_q[$];
    bit   free_q[$];

    bit_alloc_if #(.WIDTH(W)) bus();
    bit_alloc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        free_prev <= bus.free_req && !rst;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   ee;
        if (!rst) begin
            if (bus.alloc_valid || bus.alloc_fail) begin
                if (exp_q.size() == 0) check("unexpected_alloc_pulse", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("alloc_fail", int'(bus.alloc_fail), int'(e.fail));
                    check("alloc_valid", int'(bus.alloc_valid), int'(!e.fail));
                    check("alloc_cycle", cyc, e.cyc);
                    if (!e.fail) check("alloc_index", int'(bus.alloc_index), e.idx);
                    check("alloc_occ", int'(bus.occ), e.occ);
                end
            end
            if (free_prev) begin
                if (free_q.size() == 0) check("unexpected_free", 1, 0);
                else begin
                    ee = free_q.pop_front();
                    check("free_err", int'(bus.free_err), int'(ee));
                end
            end else if (bus.free_err) check("spurious_free_err", 1, 0);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.alloc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("alloc_ready", int'(bus.alloc_ready), 1);
    endtask

    // f = cycle offset after acceptance at which slot fi is freed (0 = no free)
    task automatic do_alloc(input int f, input int fi);
        exp_t e;
        bit   fin = 1'b0;
        wait_ready();
        e = '{fail: 1'b1, idx: 0, occ: 0, cyc: 0};
        for (int t = 1; t <= W + 1; t++) begin
            if (t == f) begin
                free_q.push_back(m[fi] == 1'b0);
                m[fi] = 1'b0;
            end
            if (!fin && t <= W) begin
                if (!m[t-1]) begin
                    m[t-1] = 1'b1;
                    e.fail = 1'b0;
                    e.idx  = t - 1;
                    e.occ  = int'(m);
                    e.cyc  = cyc + t + 1;
                    fin    = 1'b1;
                end else if (t == W) begin
                    e.occ = int'(m);
                    e.cyc = cyc + W + 1;
                    fin   = 1'b1;
                end
            end
        end
        exp_q.push_back(e);
        bus.alloc_req = 1'b1;
        for (int t = 1; t <= W + 1; t++) begin
            @(negedge clk);
            bus.alloc_req = 1'b0;
            if (t == 1) begin
                check("busy_in_scan", int'(bus.busy), 1);
                check("ready_in_scan", int'(bus.alloc_ready), 0);
            end
            bus.free_req   = (t == f);
            bus.free_index = 2'(fi);
        end
        @(negedge clk);
        bus.free_req = 1'b0;
    endtask

    task automatic do_free(input int fi);
        free_q.push_back(m[fi] == 1'b0);
        m[fi] = 1'b0;
        bus.free_req   = 1'b1;
        bus.free_index = 2'(fi);
        @(negedge clk);
        bus.free_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_occ(input string name, input int exp);
        check(name, int'(bus.occ), exp);
    endtask

    initial begin
        bus.alloc_req  = 1'b0;
        bus.free_req   = 1'b0;
        bus.free_index = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_occ", int'(bus.occ), 0);
        check("reset_ready", int'(bus.alloc_ready), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_valid", int'(bus.alloc_valid), 0);
        check("reset_fail", int'(bus.alloc_fail), 0);
        check("reset_err", int'(bus.free_err), 0);
        check("reset_index", int'(bus.alloc_index), 0);

        do_alloc(0, 0);
        check_occ("occ_after_first", 4'b0001);
        do_alloc(0, 0);
        do_alloc(0, 0);
        do_alloc(0, 0);
        check_occ("occ_full", 4'b1111);
        do_alloc(0, 0);
        check_occ("occ_after_fail", 4'b1111);
        do_free(2);
        check_occ("occ_after_free", 4'b1011);
        do_free(2);
        check_occ("occ_after_double_free", 4'b1011);
        do_free(3);
        do_alloc(0, 0);
        check_occ("occ_0111", 4'b0111);
        do_alloc(3, 2);
        check_occ("occ_same_edge_free", 4'b0111);
        do_alloc(2, 0);
        check_occ("occ_no_rescan", 4'b1110);

        do_alloc(0, 0);
        do_free(1);
        wait_ready();
        bus.alloc_req = 1'b1;
        @(negedge clk);
        bus.alloc_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m = '0;
        check("midscan_rst_occ", int'(bus.occ), 0);
        check("midscan_rst_ready", int'(bus.alloc_ready), 1);
        check("midscan_rst_valid", int'(bus.alloc_valid), 0);
        check("midscan_rst_fail", int'(bus.alloc_fail), 0);
        repeat (6) @(negedge clk);

        begin : held
            int n, t, k;
            exp_t e;
            wait_ready();
            n = cyc;
            t = 0;
            while (t < 10) begin
                k = -1;
                for (int i = W - 1; i >= 0; i--) if (!m[i]) k = i;
                if (k < 0) begin
                    e = '{fail: 1'b1, idx: 0, occ: int'(m), cyc: n + t + W + 1};
                    t += W + 2;
                end else begin
                    m[k] = 1'b1;
                    e = '{fail: 1'b0, idx: k, occ: int'(m), cyc: n + t + k + 2};
                    t += k + 3;
                end
                exp_q.push_back(e);
            end
            bus.alloc_req = 1'b1;
            repeat (10) @(negedge clk);
            bus.alloc_req = 1'b0;
            repeat (8) @(negedge clk);
        end

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) do_free(int'($urandom_range(0, W - 1)));
            else do_alloc(int'($urandom_range(0, W + 1)), int'($urandom_range(0, W - 1)));
        end
        repeat (10) @(negedge clk);
        check("pending_allocs", exp_q.size(), 0);
        check("pending_frees", free_q.size(), 0);
        check_occ("final_occ", int'(m));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end
endmodule
